// File: rtl/chanel_preprocessor.sv
`timescale 1ns/1ps
// chanel_preprocessor
//   Input-side channel conditioner for the computing cascade. Removes the DC
//   offset of the incoming sample stream by subtracting a sliding mean taken
//   over the last L = 2^N accepted samples, and emits the zero-mean sample,
//   widened to DEPTH_WIDTH, as a registered single-cycle valid/data pulse.
//
//   The first L accepted samples after reset or i_clr are warm-up. The
//   L-th of them produces the first o_vld, so every emitted sample is
//   computed from a full window.
//
// Parameters
//   WIDTH       input sample width
//   DEPTH_WIDTH output width (>= WIDTH+1)
//   N           log2 of window length (N >= 1)
//   SIG         1: i_data is two's complement, 0: i_data is unsigned
//
// Ports
//   clk     clock
//   rstn    asynchronous active-low reset
//   i_clr   synchronous window restart, takes priority over i_vld
//   i_vld   input sample valid
//   i_data  input sample [WIDTH-1:0]
//   o_vld   output valid, one cycle after the accepted sample
//   o_data  DC-removed sample, signed [DEPTH_WIDTH-1:0]
//
// Build option
//   CHANEL_PREPROCESSOR_ROUND_EN  when defined the mean is rounded half up
//                                 instead of floored.
module chanel_preprocessor #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WIDTH = 33,
  parameter int N           = 2,
  parameter int SIG         = 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          i_clr,
  input  logic                          i_vld,
  input  logic [WIDTH-1:0]              i_data,
  output logic                          o_vld,
  output logic signed [DEPTH_WIDTH-1:0] o_data
);

  localparam int L  = 1 << N;
  localparam int XW = WIDTH + 1;      // extended sample
  localparam int SW = WIDTH + N + 1;  // running sum
  localparam int DW = SW + 1;         // difference, headroom for any rounding

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Mean of the window from the updated running sum.
  function automatic logic signed [SW-1:0] mean_f(input logic signed [SW-1:0] s);
`ifdef CHANEL_PREPROCESSOR_ROUND_EN
    logic signed [SW:0] t;
    // One extra bit so adding half an LSB of the mean can never wrap.
    t = (SW+1)'(s) + (SW+1)'(L / 2);
    return SW'(t >>> N);
`else
    return s >>> N;
`endif
  endfunction

  state_t                  state_q, state_d;
  logic [N-1:0]            cnt_q, cnt_d;
  logic                    vld_d;
  logic                    vld_p1;

  logic signed [XW-1:0]    dly_q [L];
  logic [N-1:0]            ptr_q;
  logic signed [SW-1:0]    sum_q;

  logic signed [XW-1:0]    x_p0;
  logic signed [XW-1:0]    oldest_p0;
  logic signed [SW-1:0]    s_new_p0;
  logic signed [SW-1:0]    mean_p0;
  logic signed [DW-1:0]    d_p0;
  logic signed [DEPTH_WIDTH-1:0] data_p1;

  // ---- stage p0: extend, update sum, compute mean and difference ----
  assign x_p0      = (SIG != 0) ? {i_data[WIDTH-1], i_data} : {1'b0, i_data};
  // The slot about to be overwritten holds the oldest sample; it is zero
  // while the window is still filling after a clear or reset.
  assign oldest_p0 = dly_q[ptr_q];
  assign s_new_p0  = sum_q + SW'(x_p0) - SW'(oldest_p0);
  assign mean_p0   = mean_f(s_new_p0);
  assign d_p0      = DW'(x_p0) - DW'(mean_p0);

  // Warm-up / run sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    if (i_clr) begin
      state_d = FILL;
      cnt_d   = '0;
    end else if (i_vld) begin
      case (state_q)
        FILL: begin
          if (cnt_q == N'(L - 1)) begin
            // L-th accepted sample completes the window.
            state_d = RUN;
            vld_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN:     vld_d = 1'b1;
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FILL;
      cnt_q   <= '0;
      vld_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_p1  <= vld_d;
    end
  end

  // ---- stage p1: window storage and registered output ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < L; i++) dly_q[i] <= '0;
      ptr_q   <= '0;
      sum_q   <= '0;
      data_p1 <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < L; i++) dly_q[i] <= '0;
      ptr_q   <= '0;
      sum_q   <= '0;
    end else if (i_vld) begin
      dly_q[ptr_q] <= x_p0;
      ptr_q        <= ptr_q + 1'b1;
      sum_q        <= s_new_p0;
      data_p1      <= DEPTH_WIDTH'(d_p0);
    end
  end

  assign o_vld  = vld_p1;
  assign o_data = data_p1;

endmodule

// File: doc/chanel_preprocessor.md
Name: chanel_preprocessor

Overview:
Front-end channel conditioner feeding the computing cascade; counterpart of chanel_postprocessor on the cascade's input side.
- Takes raw channel samples (i_vld/i_data) and removes the DC offset with a sliding mean over 2^N samples.
- Emits the zero-mean sample, widened to DEPTH_WIDTH, on the same valid/data interface that the cascade consumes.
- No backpressure; one sample in per valid cycle.

Parameters:
WIDTH, 32, input sample width
DEPTH_WIDTH, 33, output width; must be >= WIDTH+1
N, 2, log2 of window length L = 2^N (N >= 1)
SIG, 1, 1 = i_data is two's-complement signed; 0 = unsigned

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
i_clr  input  1  synchronous restart of the window; has priority over i_vld
i_vld  input  1  input sample valid
i_data  input  WIDTH  input sample
o_vld  output  1  output sample valid, single-cycle pulse
o_data  output  DEPTH_WIDTH  DC-removed sample, always signed two's complement

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous, active-low (rstn); while rstn=0, everything below is held cleared.
- Reset values: o_vld=0, o_data=0, delay line all 0, running sum 0, fill counter 0, state FILL.
- Input extension: x = i_data extended to WIDTH+1 bits; sign-extend if SIG=1, zero-extend if SIG=0.
- Storage:
  - Delay line of L entries (shift register or circular buffer with N-bit write pointer wrapping L-1 -> 0).
  - Running sum S, width WIDTH+N+1, signed.
- Update, on i_vld=1 and i_clr=0:
  - S_new = S + x - x_oldest, where x_oldest is the entry being overwritten (0 during FILL after a clear).
  - x is written into the delay line; the pointer advances.
- Output arithmetic:
  - mean = S_new >>> N (arithmetic shift, floor).
  - d = x - mean, sign-extended to DEPTH_WIDTH.
- Latency: registered, exactly 1 cycle. o_vld at cycle t+1 reflects i_vld at cycle t, when the state permits.
- State machine:
  - FILL: counter counts accepted samples 0..L-1. o_vld stays 0 while d is computed. On the L-th accepted sample, go to RUN and assert o_vld for that sample, so the first output uses a full window.
  - RUN: every accepted sample produces o_vld=1 the next cycle. The counter is frozen (saturated).
- i_vld=0: no state change; o_vld=0 next cycle; o_data holds its last value.
- i_clr=1, in any state:
  - Next cycle: delay line zeroed, S=0, counter=0, state FILL, o_vld=0.
  - A concurrent i_vld sample is dropped.
- Reset mid-operation: asynchronous clear as above. The first L valid samples after release are warm-up again.
- Overflow: none by construction. S cannot overflow at width WIDTH+N+1; d fits in WIDTH+1 bits.

Optional Feature:
CHANEL_PREPROCESSOR_ROUND_EN
- Defined: mean = (S_new + 2^(N-1)) >>> N, i.e. round half up. The rounding adder is one bit wider than S.
- Undefined: floor mean via plain arithmetic shift, as in Behaviour.
- Latency and handshake are identical in both builds.

Test Plan:
1. Warm-up, SIG=1, N=2: i_vld=1 with 1, -2, 3, 4 on consecutive cycles.
   - o_vld stays 0 for the first 3 samples.
   - One cycle after sample 4: o_vld=1, o_data=3 (S=6, mean=1).
   - With ROUND_EN: o_data=2 (mean=2).
2. Steady state: continue case 1 with sample 5 -> S=10, mean=2, o_data=3; with ROUND_EN, mean=3, o_data=2. Then a gap cycle with i_vld=0 -> o_vld=0 and o_data holds 3 (or 2).
3. Negative constant: eight samples of -3 -> o_vld on samples 4..8, each o_data=0; S settles at -12.
4. Unsigned extreme, SIG=0: four samples of 0xFFFFFFFF -> mean=0xFFFFFFFF, o_data=0. Then sample 0 -> S=3*(2^32-1), mean=0xBFFFFFFF (floor), o_data=-0xBFFFFFFF as 33-bit two's complement.
5. i_clr mid-stream: after case 2, assert i_clr together with i_vld=1 and data 9.
   - Sample 9 is dropped; o_vld=0 next cycle.
   - Then 4,4,4,8 -> first o_vld after the 4th sample, o_data=3 (S=20, mean=5).
6. Async reset mid-RUN: drop rstn between clock edges -> o_vld and o_data go to 0 immediately. After release, warm-up repeats and no o_vld appears before the 4th valid sample.
